// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned PC_STEP  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Sequential successor; 32-bit arithmetic wraps 0xFFFF_FFFC to 0.
  function automatic logic [PC_WIDTH-1:0] pc_next_seq(input logic [PC_WIDTH-1:0] cur);
    return cur + PC_WIDTH'(PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load has priority over increment, async reset to RESET_PC.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                inc,
  input  logic [PC_WIDTH-1:0] load_val,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc_next_seq(pc);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/HOLD/HALTED control over an imem req/ack handshake.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets to TRAP_VEC.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                halt,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                misaligned
);

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  fetch_state_e        state_q, state_d;
  logic                flush_q, flush_d;
  logic                halt_q, halt_d;
  logic [PC_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic                mis_q;
  logic                tgt_odd_c;
  logic [PC_WIDTH-1:0] tgt_c;
  logic                pc_load, pc_inc;
  logic [PC_WIDTH-1:0] pc_load_val;

  // Effective redirect target: trap when checking, else drop the low bits.
  assign tgt_odd_c = |redirect_pc[1:0];
  assign tgt_c = ALIGN_EN ? (tgt_odd_c ? TRAP_VEC : redirect_pc)
                          : {redirect_pc[PC_WIDTH-1:2], 2'b00};

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (pc_load_val),
    .pc       (pc)
  );

  assign imem_addr  = pc;
  assign misaligned = mis_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      flush_q    <= 1'b0;
      halt_q     <= 1'b0;
      redir_pc_q <= '0;
      mis_q      <= 1'b0;
      imem_req   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      halt_q     <= halt_d;
      redir_pc_q <= redir_pc_d;
      mis_q      <= ALIGN_EN && redirect_valid && tgt_odd_c && (state_q != ST_HALTED);
      imem_req   <= (state_d == ST_FETCH);
      busy       <= (state_d == ST_FETCH) || (state_d == ST_HOLD);
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    halt_d      = halt_q;
    redir_pc_d  = redir_pc_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = tgt_c;
    instr_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_load = redirect_valid;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          // A redirect in the ack cycle itself is the latest and also flushes.
          instr_valid = !(flush_q || redirect_valid);
          if (redirect_valid) begin
            pc_load = 1'b1;
          end else if (flush_q) begin
            pc_load     = 1'b1;
            pc_load_val = redir_pc_q;
          end else begin
            pc_inc = 1'b1;
          end
          flush_d = 1'b0;
          halt_d  = 1'b0;
          if (halt || halt_q)  state_d = ST_HALTED;
          else if (stall)      state_d = ST_HOLD;
          else                 state_d = ST_FETCH;
        end else begin
          if (redirect_valid) begin
            flush_d    = 1'b1;
            redir_pc_d = tgt_c;
          end
          if (halt) halt_d = 1'b1;
        end
      end
      ST_HOLD: begin
        pc_load = redirect_valid;
        if (halt)        state_d = ST_HALTED;
        else if (!stall) state_d = ST_FETCH;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100: PC loaded on a misaligned redirect (see REQ-030).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  begin fetching from IDLE.
REQ-006 stall  in  1  pipeline stall; blocks issue of the next fetch.
REQ-007 halt  in  1  stop fetching after the outstanding fetch completes.
REQ-008 redirect_valid  in  1  branch/jump taken.
REQ-009 redirect_pc  in  32  branch/jump target.
REQ-010 imem_req  out  1  instruction-memory request.
REQ-011 imem_addr  out  32  fetch address; equals pc.
REQ-012 imem_ack  in  1  memory accepted the request and returned data.
REQ-013 instr_valid  out  1  one-cycle pulse: the acked instruction is to be executed.
REQ-014 pc  out  32  current program counter.
REQ-015 busy  out  1  high in any state except IDLE and HALTED.
REQ-016 misaligned  out  1  one-cycle pulse on a misaligned redirect target.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, FETCH, HOLD, HALTED.
REQ-018 IDLE: imem_req=0; start=1 -> FETCH on the next cycle.
REQ-019 FETCH: imem_req=1, imem_addr=pc, both held stable until the cycle imem_ack=1.
REQ-020 On imem_ack in FETCH: pc <= pending redirect target if one exists, else pc+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 On imem_ack: instr_valid=1 in the same cycle, unless the fetch is flushed (REQ-022).
REQ-022 A redirect_valid seen in FETCH, including the ack cycle, marks the outstanding fetch flushed: its instr_valid is suppressed.
  - Target latched; a later redirect before ack overwrites it (latest wins).
  - Flag cleared on ack.
REQ-023 Next state on ack, in this priority: halt (current or latched) -> HALTED; else stall -> HOLD; else FETCH, with imem_req staying high with the new address.
REQ-024 HOLD: imem_req=0.
  - stall=0 -> FETCH next cycle.
  - redirect_valid in HOLD loads pc <= redirect_pc next cycle.
  - halt in HOLD -> HALTED.
REQ-025 redirect_valid in IDLE SHALL load pc <= redirect_pc without starting a fetch.
REQ-026 HALTED: imem_req=0 and pc frozen; only reset leaves HALTED.
REQ-027 halt asserted in FETCH before ack SHALL be latched and never abort the outstanding request.
REQ-028 Handshake rule: imem_req is never deasserted while a request is outstanding without an ack, except by reset.

Reset
REQ-029 When reset asserts, in any state including mid-request, the block SHALL immediately force all of the following:
  - state=IDLE, pc=RESET_PC, imem_req=0.
  - instr_valid=0, misaligned=0, busy=0.
  - pending-redirect, flush and halt latches cleared.

Configuration
REQ-030 With macro FETCH_ALIGN_CHECK_EN defined, a redirect target with bits[1:0]!=0 SHALL:
  - pulse misaligned for one cycle;
  - set the next pc to TRAP_VEC instead of the target.
  Without the macro, redirect target bits[1:0] SHALL be forced to 2'b00 and misaligned SHALL be tied 0; the port is present in both builds.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the following, and the block SHALL import them:
  - state enum;
  - PC_WIDTH=32;
  - PC_STEP=4.
REQ-032 The PC register SHALL be a sub-module fetch_pc_reg with the following behaviour:
  - inputs: load, inc, load value;
  - async reset to RESET_PC;
  - wrap on increment.

Verification
REQ-033 reset, start, imem_ack every cycle -> imem_addr 0x0, 0x4, 0x8 with instr_valid=1 on each ack.
REQ-034 pc=0xFFFF_FFFC, ack -> pc=0x0000_0000, no X.
REQ-035 Branch flush, under FETCH addr 0x10 with ack delayed 3 cycles:
  - stimulus: redirect_valid with redirect_pc=0x200 in cycle 1;
  - response: ack yields instr_valid=0, next imem_addr=0x200.
REQ-036 stall=1 at ack of 0x20 -> HOLD, imem_req=0, pc=0x24; stall=0 -> req with addr 0x24 next cycle.
REQ-037 Halt during an outstanding fetch: halt pulsed before ack -> request held until ack, then HALTED with busy=0; reset asserted mid-FETCH -> imem_req=0 immediately, pc=RESET_PC.
REQ-038 Macro defined, redirect_pc=0x102 -> misaligned=1 for one cycle, pc=TRAP_VEC. Macro undefined -> pc=0x100, misaligned=0.
